// File: rtl/rk4_clk_ctrl.sv
// Clock-source sequencing controller for the RK4 ring-oscillator generator.
// Optional frequency measurement is enabled by defining RK4_CLK_CTRL_FMEAS_EN.
module rk4_clk_ctrl #(
  parameter int          SETTLE_CYCLES  = 16,
  parameter int          LOCK_EDGES     = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [1:0]  FALLBACK_SEL   = 2'b11
`ifdef RK4_CLK_CTRL_FMEAS_EN
  , parameter int        CNT_W          = 16,
  parameter int          WINDOW         = 4096
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic       osc_en,
  output logic [1:0] osc_sel,
  output logic       div_rst,
  input  logic       clk_div,
  output logic       locked,
  output logic [1:0] cur_sel,
  output logic       done,
  output logic       fault
`ifdef RK4_CLK_CTRL_FMEAS_EN
  , output logic [CNT_W-1:0] meas_count,
  output logic       meas_valid
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int EW = $clog2(LOCK_EDGES + 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_LAST   = EW'(LOCK_EDGES - 1);

  typedef enum logic [2:0] {IDLE, QUIESCE, SWITCH, SETTLE, CHECK, LOCKED} state_t;
  state_t state, state_nx;

  logic [1:0]    target;
  logic          fb;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [EW-1:0] edge_cnt;
  logic [2:0]    sync;
  logic          rise, accept, lock_hit, tmo_hit;

  // sync[1:0] is the synchronizer, sync[2] holds the previous sample for edge detect
  assign rise     = sync[1] & ~sync[2];
  assign accept   = req_valid & req_ready;
  assign lock_hit = rise && (edge_cnt == EDGE_LAST);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign cur_sel  = osc_sel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    locked    = 1'b0;
    div_rst   = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nx = QUIESCE;
      end
      QUIESCE: state_nx = SWITCH;
      SWITCH:  state_nx = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nx = CHECK;
      CHECK: begin
        div_rst = 1'b0;
        // lock takes priority over a coincident timeout
        if (lock_hit)     state_nx = LOCKED;
        else if (tmo_hit) state_nx = fb ? IDLE : QUIESCE;
      end
      LOCKED: begin
        req_ready = 1'b1;
        locked    = 1'b1;
        div_rst   = 1'b0;
        if (accept) state_nx = QUIESCE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      target     <= 2'b11;
      fb         <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      edge_cnt   <= '0;
      osc_sel    <= 2'b11;
      osc_en     <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      sync <= {sync[1:0], clk_div};
      done <= (state == CHECK) && (lock_hit || (tmo_hit && fb));
      if (accept) begin
        target <= req_sel;
        fb     <= 1'b0;
        fault  <= 1'b0;
      end
      if (state == SWITCH) begin
        osc_sel    <= target;
        osc_en     <= (target != 2'b11);
        settle_cnt <= '0;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SW'(1);
        tmo_cnt    <= '0;
        edge_cnt   <= '0;
      end
      if (state == CHECK) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        if (rise) edge_cnt <= edge_cnt + EW'(1);
        if (!lock_hit && tmo_hit && !fb) begin
          fault  <= 1'b1;
          target <= FALLBACK_SEL;
          fb     <= 1'b1;
        end
      end
    end
  end

`ifdef RK4_CLK_CTRL_FMEAS_EN
  localparam int WW = $clog2(WINDOW);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  logic [WW-1:0]    win_cnt;
  logic [CNT_W-1:0] acc, acc_inc;

  assign acc_inc = (rise && (acc != '1)) ? acc + CNT_W'(1) : acc;

  // window restarts whenever LOCKED is left; last result is held
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt    <= '0;
      acc        <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (state != LOCKED) begin
        win_cnt <= '0;
        acc     <= '0;
      end else if (win_cnt == WIN_LAST) begin
        win_cnt    <= '0;
        acc        <= '0;
        meas_count <= acc_inc;
        meas_valid <= 1'b1;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        acc     <= acc_inc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rk4_clk_ctrl.sv
// Directed bench for rk4_clk_ctrl: switch, fallback, double timeout, ignored request, mid-sequence reset.
module tb_rk4_clk_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'b00;
  logic       clk_div = 1'b0;
  logic       req_ready, osc_en, div_rst, locked, done, fault;
  logic [1:0] osc_sel, cur_sel;
  bit         div_run = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  rk4_clk_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .osc_en(osc_en), .osc_sel(osc_sel),
    .div_rst(div_rst), .clk_div(clk_div), .locked(locked),
    .cur_sel(cur_sel), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // generator output: toggles every 8 reference cycles when running
  initial begin
    #3;
    forever begin
      #80;
      if (div_run) clk_div = ~clk_div;
      else         clk_div = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns at the negedge following the accepting edge
  task automatic accept(input logic [1:0] sel);
    req_valid = 1'b1;
    req_sel   = sel;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_lock(input string tag);
    int i;
    i = 0;
    while (!locked && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk(tag, locked, 1);
  endtask

  initial begin
    cyc(3);
    chk("rst_osc_sel", osc_sel, 2'b11);
    chk("rst_cur_sel", cur_sel, 2'b11);
    chk("rst_osc_en", osc_en, 0);
    chk("rst_div_rst", div_rst, 1);
    chk("rst_locked", locked, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b0;
    cyc(1);

    // primary switch to osc1 with a live divider
    div_run = 1'b1;
    accept(2'b00);
    chk("t1_ready_busy", req_ready, 0);
    cyc(2);
    chk("t1_osc_sel", osc_sel, 2'b00);
    chk("t1_osc_en", osc_en, 1);
    chk("t1_div_rst_sw", div_rst, 1);
    cyc(15);
    chk("t1_div_rst_settle", div_rst, 1);
    cyc(1);
    chk("t1_div_rst_check", div_rst, 0);
    wait_lock("t1_lock");
    chk("t1_done", done, 1);
    chk("t1_fault", fault, 0);
    cyc(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_ready_locked", req_ready, 1);

    // osc3 dead, fallback to ext which runs
    div_run = 1'b0;
    accept(2'b10);
    chk("t2_locked_drop", locked, 0);
    cyc(1041);
    chk("t2_fault_pre", fault, 0);
    chk("t2_div_rst_pre", div_rst, 0);
    chk("t2_osc_sel_pre", osc_sel, 2'b10);
    cyc(1);
    chk("t2_fault", fault, 1);
    chk("t2_div_rst", div_rst, 1);
    chk("t2_no_done", done, 0);
    div_run = 1'b1;
    cyc(2);
    chk("t2_osc_sel_fb", osc_sel, 2'b11);
    chk("t2_osc_en_fb", osc_en, 0);
    wait_lock("t2_lock");
    chk("t2_done", done, 1);
    chk("t2_fault_kept", fault, 1);
    chk("t2_cur_sel", cur_sel, 2'b11);
    cyc(1);

    // competing request during SETTLE is ignored
    accept(2'b00);
    chk("t3_fault_clr", fault, 0);
    cyc(2);
    req_valid = 1'b1;
    req_sel   = 2'b01;
    cyc(1);
    chk("t3_ready_busy", req_ready, 0);
    wait_lock("t3_lock");
    req_valid = 1'b0;
    chk("t3_osc_sel", osc_sel, 2'b00);
    chk("t3_done", done, 1);
    cyc(1);

    // both attempts dead: end in IDLE with fault
    div_run = 1'b0;
    accept(2'b01);
    cyc(2083);
    chk("t4_done_pre", done, 0);
    chk("t4_div_rst_pre", div_rst, 0);
    cyc(1);
    chk("t4_done", done, 1);
    chk("t4_locked", locked, 0);
    chk("t4_fault", fault, 1);
    chk("t4_div_rst", div_rst, 1);
    chk("t4_ready", req_ready, 1);
    chk("t4_osc_sel", osc_sel, 2'b11);
    chk("t4_osc_en", osc_en, 0);
    cyc(1);
    chk("t4_done_pulse", done, 0);

    // reset during CHECK
    accept(2'b00);
    chk("t5_fault_clr", fault, 0);
    cyc(20);
    chk("t5_in_check", div_rst, 0);
    chk("t5_osc_en_pre", osc_en, 1);
    rst = 1'b1;
    cyc(1);
    chk("t5_osc_sel", osc_sel, 2'b11);
    chk("t5_osc_en", osc_en, 0);
    chk("t5_div_rst", div_rst, 1);
    chk("t5_locked", locked, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_done", done, 0);
    rst = 1'b0;
    cyc(2);
    chk("t5_done_after", done, 0);
    chk("t5_idle_div_rst", div_rst, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
